// File: rtl/fft_frame_sched_if.sv
// Signal bundle between the frame scheduler, the two acquisition FIFOs and the
// FFT sink port. The master side is the scheduler; the slave side is the FIFOs plus the FFT core.
interface fft_frame_sched_if #(
  parameter int DATA_W = 16
);
  logic              ch0_full;
  logic              ch1_full;
  logic              ch0_empty;
  logic              ch1_empty;
  logic [DATA_W-1:0] ch0_data;
  logic [DATA_W-1:0] ch1_data;
  logic              ch0_rdreq;
  logic              ch1_rdreq;
  logic              sink_ready;
  logic              sink_valid;
  logic              sink_sop;
  logic              sink_eop;
  logic [DATA_W-1:0] sink_real;
  logic              sink_ch;

  modport master (
    input  ch0_full, ch1_full, ch0_empty, ch1_empty, ch0_data, ch1_data, sink_ready,
    output ch0_rdreq, ch1_rdreq, sink_valid, sink_sop, sink_eop, sink_real, sink_ch
  );

  modport slave (
    output ch0_full, ch1_full, ch0_empty, ch1_empty, ch0_data, ch1_data, sink_ready,
    input  ch0_rdreq, ch1_rdreq, sink_valid, sink_sop, sink_eop, sink_real, sink_ch
  );
endinterface

// File: rtl/fft_frame_sched.sv
// Round-robin scheduler that feeds fixed-length frames from two show-ahead FIFOs into one FFT sink.
// Define FFT_SCHED_ZERO_PAD_EN to pad FIFO underruns with zero beats instead of stalling the frame.
module fft_frame_sched #(
  parameter int FRAME_LEN = 512,
  parameter int DATA_W    = 16,
  parameter int GAP_CYC   = 16
) (
  input  logic                clk,
  input  logic                reset,
  fft_frame_sched_if.master   bus,
  output logic                busy,
  output logic                frame_done,
  output logic                underrun_err
);
  localparam int CNT_W = $clog2(FRAME_LEN);
  localparam int GAP_W = (GAP_CYC > 1) ? $clog2(GAP_CYC) : 1;
  localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(FRAME_LEN - 1);
  localparam logic [GAP_W-1:0] LAST_GAP  = GAP_W'(GAP_CYC - 1);

  typedef enum logic [1:0] {IDLE, STREAM, GAP} state_t;

  state_t            state_reg;
  logic [1:0]        full_prev_reg;
  logic [1:0]        pend_reg;
  logic              last_grant_reg;
  logic              sink_ch_reg;
  logic [CNT_W-1:0]  cnt_reg;
  logic [GAP_W-1:0]  gap_cnt_reg;
  logic              busy_reg;
  logic              frame_done_reg;
  logic              underrun_reg;

  logic [1:0]        full_now;
  logic [1:0]        rise;
  logic [1:0]        pend_clr;
  logic              take_grant;
  logic              grant_ch;
  logic              in_stream;
  logic              sel_empty;
  logic [DATA_W-1:0] sel_data;
  logic              accept;
  logic              pop;

  assign full_now   = {bus.ch1_full, bus.ch0_full};
  assign rise       = full_now & ~full_prev_reg;
  assign take_grant = (state_reg == IDLE) && (|pend_reg);
  // With both channels waiting, the one that did not run last goes first.
  assign grant_ch   = (pend_reg == 2'b11) ? ~last_grant_reg : pend_reg[1];

  for (genvar gi = 0; gi < 2; gi++) begin : g_pend
    assign pend_clr[gi] = take_grant && (grant_ch == 1'(gi));
  end

  assign in_stream = (state_reg == STREAM);
  assign sel_empty = sink_ch_reg ? bus.ch1_empty : bus.ch0_empty;
  assign sel_data  = sink_ch_reg ? bus.ch1_data  : bus.ch0_data;

`ifdef FFT_SCHED_ZERO_PAD_EN
  assign bus.sink_valid = in_stream;
`else
  assign bus.sink_valid = in_stream && !sel_empty;
`endif

  // Zero is forced whenever no real sample is presented, which also gives the pad value.
  assign bus.sink_real = (in_stream && !sel_empty) ? sel_data : '0;
  assign accept        = bus.sink_valid && bus.sink_ready;
  assign pop           = accept && !sel_empty;
  assign bus.ch0_rdreq = pop && !sink_ch_reg;
  assign bus.ch1_rdreq = pop && sink_ch_reg;
  assign bus.sink_sop  = bus.sink_valid && (cnt_reg == '0);
  assign bus.sink_eop  = bus.sink_valid && (cnt_reg == LAST_BEAT);
  assign bus.sink_ch   = sink_ch_reg;

  assign busy         = busy_reg;
  assign frame_done   = frame_done_reg;
  assign underrun_err = underrun_reg;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg      <= IDLE;
      full_prev_reg  <= '0;
      pend_reg       <= '0;
      last_grant_reg <= 1'b1;
      sink_ch_reg    <= 1'b0;
      cnt_reg        <= '0;
      gap_cnt_reg    <= '0;
      busy_reg       <= 1'b0;
      frame_done_reg <= 1'b0;
      underrun_reg   <= 1'b0;
    end else begin
      full_prev_reg  <= full_now;
      // A fresh edge wins over the grant clear so a re-fill during the frame is queued.
      pend_reg       <= (pend_reg & ~pend_clr) | rise;
      frame_done_reg <= 1'b0;
      if (in_stream && sel_empty) begin
        underrun_reg <= 1'b1;
      end
      case (state_reg)
        IDLE: begin
          if (take_grant) begin
            sink_ch_reg    <= grant_ch;
            last_grant_reg <= grant_ch;
            cnt_reg        <= '0;
            state_reg      <= STREAM;
            busy_reg       <= 1'b1;
          end
        end
        STREAM: begin
          if (accept) begin
            if (cnt_reg == LAST_BEAT) begin
              state_reg      <= GAP;
              gap_cnt_reg    <= '0;
              frame_done_reg <= 1'b1;
            end else begin
              cnt_reg <= cnt_reg + 1'b1;
            end
          end
        end
        GAP: begin
          if (gap_cnt_reg == LAST_GAP) begin
            state_reg <= IDLE;
            busy_reg  <= 1'b0;
          end else begin
            gap_cnt_reg <= gap_cnt_reg + 1'b1;
          end
        end
        default: begin
          state_reg <= IDLE;
          busy_reg  <= 1'b0;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_fft_frame_sched.sv
// Directed bench for fft_frame_sched: two FIFO models feeding the scheduler, sink checked beat by beat.
module tb_fft_frame_sched;
  localparam int FRAME_LEN = 8;
  localparam int DATA_W    = 16;
  localparam int GAP_CYC   = 4;

  logic clk = 1'b0;
  logic reset;
  logic busy, frame_done, underrun_err;
  int   n_assert = 0;
  int   n_fail   = 0;
  int   ptr0 = 0;
  int   ptr1 = 0;
  int   exp_next[2];
  int   pops_before;

  fft_frame_sched_if #(.DATA_W(DATA_W)) bus ();

  fft_frame_sched #(
    .FRAME_LEN(FRAME_LEN),
    .DATA_W   (DATA_W),
    .GAP_CYC  (GAP_CYC)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .bus         (bus),
    .busy        (busy),
    .frame_done  (frame_done),
    .underrun_err(underrun_err)
  );

  always #5 clk = ~clk;

  // Show-ahead FIFO models: ch0 holds 0,1,2,... and ch1 holds 256,257,...
  assign bus.ch0_data = DATA_W'(ptr0);
  assign bus.ch1_data = DATA_W'(256 + ptr1);
  always @(posedge clk) begin
    if (bus.ch0_rdreq) ptr0 <= ptr0 + 1;
    if (bus.ch1_rdreq) ptr1 <= ptr1 + 1;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic set_empty(input int ch, input logic v);
    if (ch == 0) bus.ch0_empty = v;
    else         bus.ch1_empty = v;
  endtask

  task automatic set_full(input int ch, input logic v);
    if (ch == 0) bus.ch0_full = v;
    else         bus.ch1_full = v;
  endtask

  task automatic pulse_full(input logic f0, input logic f1);
    bus.ch0_full = f0;
    bus.ch1_full = f1;
    @(negedge clk);
    bus.ch0_full = 1'b0;
    bus.ch1_full = 1'b0;
  endtask

  task automatic wait_grant(input int ch);
    bit found = 1'b0;
    for (int i = 0; i < 40 && !found; i++) begin
      @(negedge clk);
      if (busy === 1'b1 && bus.sink_valid === 1'b1) found = 1'b1;
    end
    chk("grant_seen", 32'(found), 32'd1);
    chk("grant_ch", 32'(bus.sink_ch), 32'(ch));
  endtask

  // Runs one frame from its first STREAM cycle, then checks frame_done and the idle gap.
  task automatic stream_frame(input int ch, input int ready_mode, input bit hole, input int edge_ch);
    int   beat = 0;
    int   cyc = 0;
    int   hole_left = 0;
    bit   hole_done = 1'b0;
    bit   edge_done = 1'b0;
    logic emp, ev, er;
    while (beat < FRAME_LEN && cyc < 64) begin
      bus.sink_ready = (ready_mode == 0) ? 1'b1 : ((cyc % 4 == 0) || (cyc % 4 == 3));
      if (hole && !hole_done && beat == 4) begin
        hole_left = 3;
        hole_done = 1'b1;
      end
      emp = (hole_left > 0);
      set_empty(ch, emp);
      if (edge_ch >= 0) begin
        set_full(edge_ch, (beat == 2) && !edge_done);
        if (beat == 2) edge_done = 1'b1;
      end
      #1;
`ifdef FFT_SCHED_ZERO_PAD_EN
      ev = 1'b1;
`else
      ev = !emp;
`endif
      er = ev && bus.sink_ready;
      chk("sink_valid", 32'(bus.sink_valid), 32'(ev));
      if (ev) begin
        chk("sink_real", 32'(bus.sink_real), emp ? 32'd0 : 32'(exp_next[ch]));
        chk("sink_sop", 32'(bus.sink_sop), 32'(beat == 0));
        chk("sink_eop", 32'(bus.sink_eop), 32'(beat == FRAME_LEN - 1));
      end else begin
        chk("sop_stall", 32'(bus.sink_sop), 32'd0);
        chk("eop_stall", 32'(bus.sink_eop), 32'd0);
      end
      chk("rdreq_granted", 32'(ch == 0 ? bus.ch0_rdreq : bus.ch1_rdreq), 32'(er && !emp));
      chk("rdreq_other", 32'(ch == 0 ? bus.ch1_rdreq : bus.ch0_rdreq), 32'd0);
      chk("sink_ch", 32'(bus.sink_ch), 32'(ch));
      chk("busy_stream", 32'(busy), 32'd1);
      if (er) begin
        beat++;
        if (!emp) exp_next[ch]++;
      end
      if (hole_left > 0) hole_left--;
      cyc++;
      @(negedge clk);
    end
    chk("frame_beats", 32'(beat), 32'(FRAME_LEN));
    set_empty(ch, 1'b0);
    if (edge_ch >= 0) set_full(edge_ch, 1'b0);
    bus.sink_ready = 1'b1;
    chk("frame_done_pulse", 32'(frame_done), 32'd1);
    chk("valid_in_gap", 32'(bus.sink_valid), 32'd0);
    chk("busy_in_gap", 32'(busy), 32'd1);
    for (int i = 1; i < GAP_CYC; i++) begin
      @(negedge clk);
      chk("frame_done_low", 32'(frame_done), 32'd0);
      chk("busy_in_gap", 32'(busy), 32'd1);
      chk("valid_in_gap", 32'(bus.sink_valid), 32'd0);
    end
    @(negedge clk);
    chk("busy_after_gap", 32'(busy), 32'd0);
    $display("frame ch=%0d beats=%0d cycles=%0d", ch, beat, cyc);
  endtask

  initial begin
    exp_next[0] = 0;
    exp_next[1] = 256;
    reset          = 1'b1;
    bus.ch0_full   = 1'b0;
    bus.ch1_full   = 1'b0;
    bus.ch0_empty  = 1'b0;
    bus.ch1_empty  = 1'b0;
    bus.sink_ready = 1'b1;
    repeat (2) @(negedge clk);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_frame_done", 32'(frame_done), 32'd0);
    chk("rst_underrun", 32'(underrun_err), 32'd0);
    chk("rst_valid", 32'(bus.sink_valid), 32'd0);
    chk("rst_rdreq0", 32'(bus.ch0_rdreq), 32'd0);
    chk("rst_rdreq1", 32'(bus.ch1_rdreq), 32'd0);
    chk("rst_sink_ch", 32'(bus.sink_ch), 32'd0);
    reset = 1'b0;
    @(negedge clk);

    // Single ch0 frame with exact grant latency: pend one cycle, STREAM the next.
    bus.ch0_full = 1'b1;
    @(negedge clk);
    chk("lat_valid_pend", 32'(bus.sink_valid), 32'd0);
    chk("lat_busy_pend", 32'(busy), 32'd0);
    bus.ch0_full = 1'b0;
    @(negedge clk);
    stream_frame(0, 0, 1'b0, -1);
    chk("no_underrun", 32'(underrun_err), 32'd0);

    // Simultaneous requests after reset: ch0, then ch1 immediately after the gap; twice.
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    for (int pair = 0; pair < 2; pair++) begin
      pulse_full(1'b1, 1'b1);
      wait_grant(0);
      stream_frame(0, 0, 1'b0, -1);
      @(negedge clk);
      chk("rr_next_valid", 32'(bus.sink_valid), 32'd1);
      chk("rr_next_ch", 32'(bus.sink_ch), 32'd1);
      stream_frame(1, 0, 1'b0, -1);
    end

    // Backpressure 1,0,0,1: every sample once, exactly FRAME_LEN pops.
    pops_before = ptr0;
    pulse_full(1'b1, 1'b0);
    wait_grant(0);
    stream_frame(0, 1, 1'b0, -1);
    chk("bp_pops", 32'(ptr0 - pops_before), 32'(FRAME_LEN));

    // FIFO runs dry for three cycles after beat 3.
    pops_before = ptr0;
    pulse_full(1'b1, 1'b0);
    wait_grant(0);
    stream_frame(0, 0, 1'b1, -1);
    chk("hole_underrun", 32'(underrun_err), 32'd1);
`ifdef FFT_SCHED_ZERO_PAD_EN
    chk("hole_pops", 32'(ptr0 - pops_before), 32'(FRAME_LEN - 3));
`else
    chk("hole_pops", 32'(ptr0 - pops_before), 32'(FRAME_LEN));
`endif

    // ch0 refills during its own frame: a second ch0 frame follows the gap.
    pulse_full(1'b1, 1'b0);
    wait_grant(0);
    stream_frame(0, 0, 1'b0, 0);
    @(negedge clk);
    chk("requeue_valid", 32'(bus.sink_valid), 32'd1);
    chk("requeue_ch", 32'(bus.sink_ch), 32'd0);
    stream_frame(0, 0, 1'b0, -1);
    chk("underrun_sticky", 32'(underrun_err), 32'd1);

    // Asynchronous reset while beat 5 is presented.
    pulse_full(1'b1, 1'b0);
    wait_grant(0);
    for (int b = 0; b < 5; b++) begin
      chk("pre_rst_data", 32'(bus.sink_real), 32'(exp_next[0]));
      exp_next[0]++;
      @(negedge clk);
    end
    chk("pre_rst_beat5", 32'(bus.sink_real), 32'(exp_next[0]));
    #2;
    reset = 1'b1;
    #1;
    chk("arst_valid", 32'(bus.sink_valid), 32'd0);
    chk("arst_sop", 32'(bus.sink_sop), 32'd0);
    chk("arst_eop", 32'(bus.sink_eop), 32'd0);
    chk("arst_rdreq0", 32'(bus.ch0_rdreq), 32'd0);
    chk("arst_rdreq1", 32'(bus.ch1_rdreq), 32'd0);
    chk("arst_busy", 32'(busy), 32'd0);
    chk("arst_frame_done", 32'(frame_done), 32'd0);
    chk("arst_underrun", 32'(underrun_err), 32'd0);
    chk("arst_sink_ch", 32'(bus.sink_ch), 32'd0);
    chk("arst_real", 32'(bus.sink_real), 32'd0);
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    pulse_full(1'b0, 1'b1);
    wait_grant(1);
    stream_frame(1, 0, 1'b0, -1);
    repeat (10) @(negedge clk);
    chk("no_stale_pend_busy", 32'(busy), 32'd0);
    chk("no_stale_pend_valid", 32'(bus.sink_valid), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule

// File: doc/fft_frame_sched.md
# fft_frame_sched

- Round-robin frame scheduler that shares one streaming FFT core between two sample FIFOs (channel 0 and channel 1).
- Detects a FIFO filling up, grants that channel, and streams exactly FRAME_LEN samples into the FFT sink with Avalon-ST sop/eop framing under sink_ready backpressure.
- Inserts a fixed idle gap between frames.
- Sits between the per-channel acquisition FIFOs and the FFT core's sink port, replacing single-channel fixed-count start logic.

## Interface
Parameters:
- FRAME_LEN, 512: samples per FFT frame (≥2).
- DATA_W, 16: sample width.
- GAP_CYC, 16: idle cycles between frames (≥1).

Ports (one clock; reset is asynchronous and active-high):
- clk  in  1  system clock.
- reset  in  1  asynchronous, active-high reset.
- ch0_full, ch1_full  in  1  FIFO full flags.
- ch0_empty, ch1_empty  in  1  FIFO empty flags.
- ch0_data, ch1_data  in  DATA_W  show-ahead FIFO output data, valid whenever not empty.
- ch0_rdreq, ch1_rdreq  out  1  FIFO read acknowledge.
- sink_ready  in  1  FFT core ready.
- sink_valid, sink_sop, sink_eop  out  1  FFT sink handshake and framing.
- sink_real  out  DATA_W  sample to FFT.
- sink_ch  out  1  granted channel; also drives the upstream filter mux select.
- busy  out  1  high outside IDLE.
- frame_done  out  1  one-cycle pulse after the last beat of a frame is accepted.
- underrun_err  out  1  sticky; set on an empty FIFO mid-frame. Cleared only by reset.

## Operation
- Pending flags:
  - pend[i] is set on a rising edge of chi_full (registered previous value vs current).
  - pend[i] is cleared in the cycle channel i is granted.
  - A rising edge on the granted channel while its frame is in progress sets pend again (queued).
- FSM IDLE -> STREAM -> GAP -> IDLE.
- IDLE:
  - If exactly one pend is set, grant that channel.
  - If both are set, grant the channel not granted last (last_grant resets to 1, so ch0 wins first).
  - On a grant: sink_ch <= channel, beat counter cnt <= 0, go to STREAM.
- STREAM:
  - sink_valid = !empty(granted).
  - sink_real = granted data.
  - rdreq(granted) = sink_valid && sink_ready. The non-granted rdreq is always 0.
  - A beat is accepted when sink_valid && sink_ready; cnt increments on each accept.
  - sink_sop = sink_valid && cnt==0.
  - sink_eop = sink_valid && cnt==FRAME_LEN-1.
  - Accept with cnt==FRAME_LEN-1: go to GAP, gap counter <= 0, frame_done pulses next cycle.
  - Empty granted FIFO mid-frame: underrun_err <= 1, plus the behaviour per Configuration.
- GAP: count GAP_CYC cycles, then go to IDLE. Pend edges continue to be captured during GAP.
- cnt width is clog2(FRAME_LEN); it never wraps inside a frame.
- Reset (asynchronous, any state, including mid-frame):
  - State IDLE; pend, cnt and gap counter = 0; last_grant = 1.
  - busy, frame_done, sink_ch, underrun_err = 0.
  - Combinational outputs sink_valid/sop/eop and both rdreq are 0, because the state is IDLE.
  - A frame partially delivered before reset is abandoned with no eop.

## Timing
- sink_valid, sink_sop, sink_eop, sink_real and rdreq are combinational from registered state and FIFO show-ahead outputs. Zero-latency FIFO-to-sink path, one FIFO pop per accepted beat.
- Grant latency:
  - Full rising edge at cycle t -> pend set at t+1 -> grant/STREAM at t+2.
  - First sink_valid at t+2 if the FIFO is non-empty.
- sink_ready low holds sink_valid and data stable. No pop, cnt unchanged.
- Frame-to-frame: the last accept at cycle e, so IDLE at e+1+GAP_CYC and the next grant at the earliest e+1+GAP_CYC.
- frame_done is registered: high exactly at e+1.
- busy is registered from state and rises the cycle after the grant decision.

## Configuration
- FFT_SCHED_ZERO_PAD_EN defined:
  - On granted FIFO empty in STREAM, sink_valid stays 1 with sink_real = 0 and rdreq = 0.
  - Padded beats count toward FRAME_LEN, so frame length is always exact and the FFT never stalls.
- Undefined:
  - sink_valid drops while the FIFO is empty. The frame stalls until data arrives.
  - cnt is held, and sop/eop are never emitted on stalled cycles.
- underrun_err is set in both builds.

## Test plan
- Single channel, FRAME_LEN=8, GAP_CYC=4, ch0 full edge, sink_ready=1 -> 8 contiguous beats with ch0 data 0..7, sop on beat 0, eop on beat 7, frame_done one cycle after, sink_ch=0.
- Both full edges in the same cycle -> ch0 frame, 4-cycle gap, then ch1 frame. A second simultaneous pair -> ch0 then ch1 again (round-robin preserved).
- sink_ready toggling 1,0,0,1,... during a frame -> no duplicated or dropped samples, rdreq only on accepted cycles, exactly 8 pops.
- ch0 empty for 3 cycles after beat 3:
  - Macro undefined: sink_valid=0 for 3 cycles, 8 real samples, underrun_err=1.
  - Macro defined: 3 zero beats inserted, eop on the 8th beat, underrun_err=1.
- Reset asserted mid-frame at beat 5 -> all outputs 0 asynchronously. After release, a new ch1 full edge -> fresh frame starting with sop, no stale pend.
- ch0 full edge during ch0's own frame -> second ch0 frame granted after the gap.
